// File: rtl/onewire_pkg.sv
// Shared types, CRC constant and default timing for the 1-Wire ROM reader.
// Timing values are in microseconds; the reader counts them on a 1 us tick.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_REL,
        ST_WR_BIT,
        ST_RD_BIT,
        ST_CHECK,
        ST_RETRY,
        ST_FINISH
    } ow_state_t;

    // x^8+x^5+x^4+1, bit-reversed for LSB-first shifting
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    localparam int DEF_CLKS_PER_US = 100;
    localparam int DEF_N_BYTES     = 8;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_T_RST_US    = 480;
    localparam int DEF_T_PRES_US   = 70;
    localparam int DEF_T_SLOT_US   = 70;
    localparam int DEF_T_LOW1_US   = 6;
    localparam int DEF_T_LOW0_US   = 60;
    localparam int DEF_T_SAMP_US   = 12;
    localparam int DEF_T_REC_US    = 10;

    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       b
    );
        logic fb;
        fb = crc[0] ^ b;
        crc8_step = (crc >> 1) ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onewire_rom_reader_if.sv
// Control/result bundle between the ROM reader and its client.
// The client (master) raises go; the reader (slave) reports status and data.
interface onewire_rom_reader_if #(
    parameter int N_BYTES = 8
);

    logic                 go;
    logic                 busy;
    logic                 done;
    logic                 err_pres;
    logic                 err_crc;
    logic [8*N_BYTES-1:0] result;
    logic [3:0]           tries;

    modport master (
        output go,
        input  busy,
        input  done,
        input  err_pres,
        input  err_crc,
        input  result,
        input  tries
    );

    modport slave (
        input  go,
        output busy,
        output done,
        output err_pres,
        output err_crc,
        output result,
        output tries
    );

endinterface

// File: rtl/onewire_crc8.sv
// Dallas/Maxim CRC-8, one bit per enable, LSB-first, init 0.
// clr has priority so a new attempt always starts from a zero remainder.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/onewire_rom_reader.sv
// 1-Wire bus master: reset/presence, one command byte, N_BYTES readback,
// CRC-8 check with bounded retries. Open-drain pad driven through ow_oe.
module onewire_rom_reader
    import onewire_pkg::*;
#(
    parameter int         CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int         N_BYTES     = DEF_N_BYTES,
    parameter logic [7:0] CMD         = 8'h33,
    parameter int         MAX_TRIES   = DEF_MAX_TRIES,
    parameter int         T_RST_US    = DEF_T_RST_US,
    parameter int         T_PRES_US   = DEF_T_PRES_US,
    parameter int         T_SLOT_US   = DEF_T_SLOT_US,
    parameter int         T_LOW1_US   = DEF_T_LOW1_US,
    parameter int         T_LOW0_US   = DEF_T_LOW0_US,
    parameter int         T_SAMP_US   = DEF_T_SAMP_US,
    parameter int         T_REC_US    = DEF_T_REC_US
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ow_in,
    output logic                 ow_oe,
    onewire_rom_reader_if.slave  bus
);

    localparam int NBITS  = 8 * N_BYTES;
    localparam int T_FULL = T_SLOT_US + T_REC_US;
    localparam int T_MAX  = max_int(T_RST_US, T_FULL);
    localparam int PW     = $clog2(CLKS_PER_US + 1);
    localparam int TW     = $clog2(T_MAX + 1);
    localparam int IW     = $clog2(NBITS + 1);

    ow_state_t        state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             us_tick;
    logic             sync1_q, sync2_q;
    logic [TW-1:0]    t_q, t_d, t_inc;
    logic [IW-1:0]    idx_q, idx_d;
    logic             pres_q, pres_d;
    logic             cause_crc_q, cause_crc_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_pres_q, err_pres_d;
    logic             err_crc_q, err_crc_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [3:0]       tries_q, tries_d;
    logic             crc_clr;
    logic             crc_en;
    logic [7:0]       crc;
    logic [7:0]       cmd_sh;
    logic [TW-1:0]    low_len;

    assign us_tick = (pre_q == PW'(CLKS_PER_US - 1));
    assign t_inc   = t_q + 1'b1;

    onewire_crc8 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (sync2_q),
        .crc    (crc)
    );

    always_comb begin
        pre_d       = us_tick ? '0 : pre_q + 1'b1;
        state_d     = state_q;
        t_d         = t_q;
        idx_d       = idx_q;
        pres_d      = pres_q;
        cause_crc_d = cause_crc_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_pres_d  = err_pres_q;
        err_crc_d   = err_crc_q;
        result_d    = result_q;
        tries_d     = tries_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        cmd_sh      = CMD >> idx_q;
        low_len     = cmd_sh[0] ? TW'(T_LOW1_US)
                                : TW'(T_LOW0_US);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    err_pres_d = 1'b0;
                    err_crc_d  = 1'b0;
                    result_d   = '0;
                    tries_d    = 4'd1;
                    busy_d     = 1'b1;
                    oe_d       = 1'b1;
                    t_d        = '0;
                    idx_d      = '0;
                    crc_clr    = 1'b1;
                    state_d    = ST_RST_LOW;
                end
            end

            ST_RST_LOW: begin
                if (us_tick) begin
                    t_d = t_inc;
                    if (t_inc == TW'(T_RST_US)) begin
                        oe_d    = 1'b0;
                        t_d     = '0;
                        pres_d  = 1'b0;
                        state_d = ST_RST_REL;
                    end
                end
            end

            // A slave still holding the bus at window end counts as present
            ST_RST_REL: begin
                if (us_tick) begin
                    t_d = t_inc;
                    if (t_inc == TW'(T_PRES_US)) begin
                        pres_d = !sync2_q;
                    end
                    if (t_inc == TW'(T_RST_US)) begin
                        t_d = '0;
                        if (pres_q) begin
                            idx_d   = '0;
                            oe_d    = 1'b1;
                            state_d = ST_WR_BIT;
                        end else begin
                            cause_crc_d = 1'b0;
                            state_d     = ST_RETRY;
                        end
                    end
                end
            end

            ST_WR_BIT: begin
                if (us_tick) begin
                    t_d = t_inc;
                    if (t_inc == low_len) begin
                        oe_d = 1'b0;
                    end
                    if (t_inc == TW'(T_FULL)) begin
                        t_d  = '0;
                        oe_d = 1'b1;
                        if (idx_q == IW'(7)) begin
                            idx_d   = '0;
                            state_d = ST_RD_BIT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end

            ST_RD_BIT: begin
                if (us_tick) begin
                    t_d = t_inc;
                    if (t_inc == TW'(T_LOW1_US)) begin
                        oe_d = 1'b0;
                    end
                    if (t_inc == TW'(T_SAMP_US)) begin
                        crc_en   = 1'b1;
                        result_d = result_q
                                 | (NBITS'(sync2_q) << idx_q);
                    end
                    if (t_inc == TW'(T_FULL)) begin
                        t_d = '0;
                        if (idx_q == IW'(NBITS - 1)) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            oe_d  = 1'b1;
                        end
                    end
                end
            end

            // Remainder over data+CRC byte is zero for a good read
            ST_CHECK: begin
                if (crc == 8'h00) begin
                    state_d = ST_FINISH;
                end else begin
                    cause_crc_d = 1'b1;
                    state_d     = ST_RETRY;
                end
            end

            ST_RETRY: begin
                if (tries_q == 4'(MAX_TRIES)) begin
                    err_pres_d = !cause_crc_q;
                    err_crc_d  = cause_crc_q;
                    state_d    = ST_FINISH;
                end else begin
                    tries_d  = tries_q + 4'd1;
                    result_d = '0;
                    crc_clr  = 1'b1;
                    oe_d     = 1'b1;
                    t_d      = '0;
                    idx_d    = '0;
                    state_d  = ST_RST_LOW;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            t_q         <= '0;
            idx_q       <= '0;
            pres_q      <= 1'b0;
            cause_crc_q <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_pres_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            result_q    <= '0;
            tries_q     <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            sync1_q     <= ow_in;
            sync2_q     <= sync1_q;
            t_q         <= t_d;
            idx_q       <= idx_d;
            pres_q      <= pres_d;
            cause_crc_q <= cause_crc_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_pres_q  <= err_pres_d;
            err_crc_q   <= err_crc_d;
            result_q    <= result_d;
            tries_q     <= tries_d;
        end
    end

    assign ow_oe        = oe_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err_pres = err_pres_q;
    assign bus.err_crc  = err_crc_q;
    assign bus.result   = result_q;
    assign bus.tries    = tries_q;

endmodule

// File: tb/tb_onewire_rom_reader.sv
// Directed bench: open-drain slave model wired-AND with ow_oe.
// Main reader runs 1 clk/us; the 2-byte CMD F0 reader runs 4 clks/us.
module tb_onewire_rom_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic oe1, oe2;
    logic ow_in1, ow_in2;
    logic s_pull = 1'b0;
    logic sel2 = 1'b0;
    logic present = 1'b1;

    onewire_rom_reader_if #(.N_BYTES(8)) bus1();
    onewire_rom_reader_if #(.N_BYTES(2)) bus2();

    onewire_rom_reader #(
        .CLKS_PER_US (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .ow_in (ow_in1),
        .ow_oe (oe1),
        .bus   (bus1)
    );

    onewire_rom_reader #(
        .CLKS_PER_US (4),
        .N_BYTES     (2),
        .CMD         (8'hF0)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .ow_in (ow_in2),
        .ow_oe (oe2),
        .bus   (bus2)
    );

    assign ow_in1 = !(oe1 || (s_pull && !sel2));
    assign ow_in2 = !(oe2 || (s_pull && sel2));
    wire m_oe = sel2 ? oe2 : oe1;

    int errors = 0;
    int checks = 0;

    logic [7:0] rom [8];
    int         rst_cnt = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] wr_byte = 8'h00;
    longint     rst_len [4];
    bit         corrupt_arm = 1'b0;
    bit         corrupt_now = 1'b0;
    int         dcnt1 = 0;

    function automatic logic rom_bit(input int bi);
        logic [7:0] b;
        b = rom[bi / 8];
        return b[bi % 8];
    endfunction

    // Maxim reference CRC-8 over rom[0..n-1]
    function automatic logic [7:0] crc_rom(input int n);
        logic [7:0] c;
        logic [7:0] d;
        logic       mix;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            d = rom[i];
            for (int k = 0; k < 8; k++) begin
                mix = c[0] ^ d[0];
                c = c >> 1;
                if (mix) c = c ^ 8'h8C;
                d = d >> 1;
            end
        end
        return c;
    endfunction

    // Slave: classify each low pulse as reset, write slot or read slot
    longint t0, dur;
    int     ut;
    logic   sb;
    int     bi;
    initial begin
        forever begin
            @(posedge m_oe);
            t0 = $time;
            ut = sel2 ? 40 : 10;
            @(negedge m_oe);
            dur = $time - t0;
            if (dur > 300 * ut) begin
                rst_len[rst_cnt % 4] = dur;
                rst_cnt++;
                wr_cnt = 0;
                rd_cnt = 0;
                wr_byte = 8'h00;
                corrupt_now = corrupt_arm;
                corrupt_arm = 1'b0;
                if (present) begin
                    #(20 * ut);
                    s_pull = 1'b1;
                    #(120 * ut);
                    s_pull = 1'b0;
                end
            end else if (wr_cnt < 8) begin
                if (dur < 15 * ut) wr_byte[wr_cnt] = 1'b1;
                wr_cnt++;
            end else begin
                bi = rd_cnt;
                rd_cnt++;
                sb = rom_bit(bi);
                if (corrupt_now && bi == 24) sb = !sb;
                if (!sb) begin
                    s_pull = 1'b1;
                    #(30 * ut - dur);
                    s_pull = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) if (bus1.done) dcnt1++;

    task automatic load_rom8();
        rom[0] = 8'h01; rom[1] = 8'h23;
        rom[2] = 8'h45; rom[3] = 8'h67;
        rom[4] = 8'h89; rom[5] = 8'hAB;
        rom[6] = 8'hCD;
        rom[7] = crc_rom(7);
    endtask

    task automatic pulse_go1();
        bus1.go = 1'b1;
        @(negedge clk);
        bus1.go = 1'b0;
    endtask

    task automatic wait_done1(input int max_cyc, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done got=0 exp=1 (timeout)", nm);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({oe1, bus1.busy, bus1.done, bus1.err_pres, bus1.err_crc} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got=%b exp=00000",
                     {oe1, bus1.busy, bus1.done, bus1.err_pres, bus1.err_crc});
        end
        checks++;
        if (bus1.tries !== 4'd0 || bus1.result !== 64'd0) begin
            errors++;
            $display("FAIL rst_data got=%h/%h exp=0/0", bus1.tries, bus1.result);
        end
    endtask

    task automatic test_rom_read();
        logic [63:0] exp;
        int r0;
        load_rom8();
        present = 1'b1;
        exp = {rom[7], 56'hCDAB8967452301};
        r0 = rst_cnt;
        pulse_go1();
        wait_done1(20000, "t1_done");
        checks++;
        if (bus1.result !== exp) begin
            errors++;
            $display("FAIL t1_result got=%h exp=%h", bus1.result, exp);
        end
        checks++;
        if ({bus1.err_pres, bus1.err_crc, bus1.tries} !== 6'b00_0001) begin
            errors++;
            $display("FAIL t1_status got=%b%b/%0d exp=00/1",
                     bus1.err_pres, bus1.err_crc, bus1.tries);
        end
        checks++;
        if (wr_cnt !== 8 || wr_byte !== 8'h33) begin
            errors++;
            $display("FAIL t1_write got=%0d/%h exp=8/33", wr_cnt, wr_byte);
        end
        checks++;
        if (rd_cnt !== 64 || rst_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL t1_slots got=%0d/%0d exp=64/1", rd_cnt, rst_cnt - r0);
        end
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_pulse got=%b%b exp=00", bus1.done, bus1.busy);
        end
    endtask

    task automatic test_no_slave();
        int r0;
        present = 1'b0;
        r0 = rst_cnt;
        pulse_go1();
        wait_done1(5000, "t2_done");
        checks++;
        if (rst_cnt - r0 !== 3) begin
            errors++;
            $display("FAIL t2_pulses got=%0d exp=3", rst_cnt - r0);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rst_len[(r0 + k) % 4] < 4790 || rst_len[(r0 + k) % 4] > 4810) begin
                errors++;
                $display("FAIL t2_len%0d got=%0d exp=4800", k, rst_len[(r0 + k) % 4]);
            end
        end
        checks++;
        if ({bus1.err_pres, bus1.err_crc, bus1.tries} !== 6'b10_0011) begin
            errors++;
            $display("FAIL t2_status got=%b%b/%0d exp=10/3",
                     bus1.err_pres, bus1.err_crc, bus1.tries);
        end
        checks++;
        if (bus1.result !== 64'd0) begin
            errors++;
            $display("FAIL t2_result got=%h exp=0", bus1.result);
        end
        present = 1'b1;
    endtask

    task automatic test_crc_retry();
        logic [63:0] exp;
        int r0;
        exp = {rom[7], 56'hCDAB8967452301};
        corrupt_arm = 1'b1;
        r0 = rst_cnt;
        pulse_go1();
        wait_done1(20000, "t3_done");
        checks++;
        if ({bus1.err_pres, bus1.err_crc, bus1.tries} !== 6'b00_0010) begin
            errors++;
            $display("FAIL t3_status got=%b%b/%0d exp=00/2",
                     bus1.err_pres, bus1.err_crc, bus1.tries);
        end
        checks++;
        if (bus1.result !== exp || rst_cnt - r0 !== 2) begin
            errors++;
            $display("FAIL t3_result got=%h/%0d exp=%h/2",
                     bus1.result, rst_cnt - r0, exp);
        end
    endtask

    task automatic test_reset_mid_slot();
        bit hit;
        hit = 1'b0;
        pulse_go1();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (rd_cnt == 20 && oe1 === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL t4_slot20 got=0 exp=1 (timeout)");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (oe1 !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL t4_release got=%b%b%b exp=000", oe1, bus1.busy, bus1.done);
        end
        checks++;
        if (bus1.result !== 64'd0 || bus1.tries !== 4'd0) begin
            errors++;
            $display("FAIL t4_clear got=%h/%0d exp=0/0", bus1.result, bus1.tries);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
    endtask

    task automatic test_go_while_busy();
        logic [63:0] exp;
        int d0;
        int r0;
        exp = {rom[7], 56'hCDAB8967452301};
        d0 = dcnt1;
        r0 = rst_cnt;
        pulse_go1();
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (i % 700 == 350 && bus1.busy === 1'b1) begin
                pulse_go1();
            end
        end
        checks++;
        if (dcnt1 - d0 !== 1 || rst_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL t5_once got=%0d/%0d exp=1/1", dcnt1 - d0, rst_cnt - r0);
        end
        checks++;
        if (bus1.result !== exp || bus1.busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_result got=%h/%b exp=%h/0", bus1.result, bus1.busy, exp);
        end
        checks++;
        if ({bus1.err_pres, bus1.err_crc, bus1.tries} !== 6'b00_0001) begin
            errors++;
            $display("FAIL t5_status got=%b%b/%0d exp=00/1",
                     bus1.err_pres, bus1.err_crc, bus1.tries);
        end
    endtask

    task automatic test_two_byte();
        logic [15:0] exp;
        bit seen;
        sel2 = 1'b1;
        rom[0] = 8'h5A;
        rom[1] = crc_rom(1);
        exp = {rom[1], 8'h5A};
        bus2.go = 1'b1;
        @(negedge clk);
        bus2.go = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus2.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t6_done got=0 exp=1 (timeout)");
        end
        checks++;
        if (bus2.result !== exp) begin
            errors++;
            $display("FAIL t6_result got=%h exp=%h", bus2.result, exp);
        end
        checks++;
        if ({bus2.err_pres, bus2.err_crc, bus2.tries} !== 6'b00_0001) begin
            errors++;
            $display("FAIL t6_status got=%b%b/%0d exp=00/1",
                     bus2.err_pres, bus2.err_crc, bus2.tries);
        end
        checks++;
        if (wr_byte !== 8'hF0 || wr_cnt !== 8 || rd_cnt !== 16) begin
            errors++;
            $display("FAIL t6_slots got=%h/%0d/%0d exp=F0/8/16", wr_byte, wr_cnt, rd_cnt);
        end
        sel2 = 1'b0;
    endtask

    initial begin
        bus1.go = 1'b0;
        bus2.go = 1'b0;
        test_reset();
        test_rom_read();
        test_no_slave();
        test_crc_retry();
        test_reset_mid_slot();
        test_go_while_busy();
        test_two_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
